// File: rtl/spi_target_pkg.sv
// Shared types and frame constants for the SPI target responder.
package spi_target_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HDR     = 2'd1,
    S_RD_DATA = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  localparam int HDR_BITS = 17;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 8;

  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/spi_target_responder_if.sv
// SPI pin bundle between the control-board driver (master) and the responder (slave).
interface spi_target_responder_if;
  logic spi_clk;
  logic mosi;
  logic miso;

  modport master (output spi_clk, output mosi, input miso);
  modport slave  (input spi_clk, input mosi, output miso);
endinterface

// File: rtl/spi_edge_sync.sv
// Oversampling synchronizer for a slow serial clock/data pair; emits registered edge pulses.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk_in,
  input  logic din,
  output logic mosi_s,
  output logic sclk_rise,
  output logic sclk_fall
);

  logic [SYNC_STAGES-1:0] sclk_sync_reg;
  logic [SYNC_STAGES-1:0] din_sync_reg;
  logic sclk_prev_reg;
  logic mosi_s_reg;
  logic rise_reg;
  logic fall_reg;
  logic sclk_last;

  assign sclk_last = sclk_sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_reg <= '0;
      din_sync_reg  <= '0;
      sclk_prev_reg <= 1'b0;
      mosi_s_reg    <= 1'b0;
      rise_reg      <= 1'b0;
      fall_reg      <= 1'b0;
    end else begin
      sclk_sync_reg[0] <= sclk_in;
      din_sync_reg[0]  <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync_reg[i] <= sclk_sync_reg[i-1];
        din_sync_reg[i]  <= din_sync_reg[i-1];
      end
      sclk_prev_reg <= sclk_last;
      // Data is registered alongside the pulses so they stay cycle-aligned.
      mosi_s_reg    <= din_sync_reg[SYNC_STAGES-1];
      rise_reg      <= sclk_last & ~sclk_prev_reg;
      fall_reg      <= ~sclk_last & sclk_prev_reg;
    end
  end

  assign mosi_s    = mosi_s_reg;
  assign sclk_rise = rise_reg;
  assign sclk_fall = fall_reg;

endmodule

// File: rtl/spi_target_responder.sv
// SPI register-bank responder: decodes write / multi-byte read frames from an oversampled SPI bus.
module spi_target_responder
  import spi_target_pkg::*;
#(
  parameter int NUM_REGS     = 16,
  parameter int IDLE_TIMEOUT = 64,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_target_responder_if.slave spi,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic                  wr_strobe,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic                  busy,
  output logic                  frame_error
);

  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [1:0] IDLE    = S_IDLE;
  localparam logic [1:0] HDR     = S_HDR;
  localparam logic [1:0] RD_DATA = S_RD_DATA;
  localparam logic [1:0] DONE    = S_DONE;

  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .sclk_in   (spi.spi_clk),
    .din       (spi.mosi),
    .mosi_s    (mosi_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall)
  );

  logic [1:0]            state_reg;
  logic [4:0]            bit_cnt_reg;
  // Holds the header bits already received; the current bit is appended combinationally.
  logic [HDR_BITS-2:0]   hdr_reg;
  logic [IDLE_W-1:0]     idle_cnt_reg;
  logic [ADDR_W-1:0]     rd_ptr_reg;
  logic [DATA_W-1:0]     byte_cnt_reg;
  logic [DATA_W-1:0]     tx_reg;
  logic [2:0]            tx_bits_reg;
  logic                  miso_reg;
  logic                  wr_strobe_reg;
  logic [ADDR_W-1:0]     wr_addr_reg;
  logic [DATA_W-1:0]     wr_data_reg;
  logic                  frame_error_reg;
  logic [DATA_W-1:0]     regs_mem [NUM_REGS];

  logic [HDR_BITS-1:0]   hdr_shift;
  logic                  hdr_rw;
  logic [ADDR_W-1:0]     hdr_addr;
  logic [DATA_W-1:0]     hdr_data;
  logic                  hdr_last;
  logic                  addr_ok;
  logic                  write_commit;
  logic [DATA_W-1:0]     rd_byte;
  logic                  timeout;

  assign hdr_shift    = {hdr_reg, mosi_s};
  assign hdr_rw       = hdr_shift[HDR_BITS-1];
  assign hdr_addr     = hdr_shift[HDR_BITS-2 -: ADDR_W];
  assign hdr_data     = hdr_shift[DATA_W-1:0];
  assign hdr_last     = (bit_cnt_reg == 5'(HDR_BITS - 1));
  assign addr_ok      = int'(hdr_addr) < NUM_REGS;
  assign write_commit = (state_reg == HDR) && sclk_rise && hdr_last
                        && (hdr_rw == RW_WRITE) && addr_ok;
  assign rd_byte      = (int'(rd_ptr_reg) < NUM_REGS) ? regs_mem[rd_ptr_reg[IDX_W-1:0]] : '0;
  assign timeout      = (state_reg != IDLE) && (idle_cnt_reg == IDLE_W'(IDLE_TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_mem[i] <= '0;
      end
    end else if (write_commit) begin
      regs_mem[hdr_addr[IDX_W-1:0]] <= hdr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      bit_cnt_reg     <= '0;
      hdr_reg         <= '0;
      idle_cnt_reg    <= '0;
      rd_ptr_reg      <= '0;
      byte_cnt_reg    <= '0;
      tx_reg          <= '0;
      tx_bits_reg     <= '0;
      miso_reg        <= 1'b0;
      wr_strobe_reg   <= 1'b0;
      wr_addr_reg     <= '0;
      wr_data_reg     <= '0;
      frame_error_reg <= 1'b0;
    end else begin
      wr_strobe_reg   <= 1'b0;
      frame_error_reg <= 1'b0;

      if (sclk_rise || sclk_fall || state_reg == IDLE) begin
        idle_cnt_reg <= '0;
      end else if (!timeout) begin
        idle_cnt_reg <= idle_cnt_reg + 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (sclk_rise) begin
            state_reg   <= HDR;
            hdr_reg     <= {{(HDR_BITS-2){1'b0}}, mosi_s};
            bit_cnt_reg <= 5'd1;
          end
        end
        HDR: begin
          if (sclk_rise) begin
            hdr_reg     <= hdr_shift[HDR_BITS-2:0];
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (hdr_last) begin
              if (hdr_rw == RW_WRITE) begin
                state_reg <= DONE;
                if (addr_ok) begin
                  wr_strobe_reg <= 1'b1;
                  wr_addr_reg   <= hdr_addr;
                  wr_data_reg   <= hdr_data;
                end
              end else if (hdr_data == '0) begin
                state_reg <= DONE;
              end else begin
                state_reg    <= RD_DATA;
                rd_ptr_reg   <= hdr_addr;
                byte_cnt_reg <= hdr_data;
                tx_bits_reg  <= '0;
              end
            end
          end
        end
        RD_DATA: begin
          if (sclk_fall) begin
            if (tx_bits_reg == '0) begin
              // Byte boundary: fetch the next register or finish the burst.
              if (byte_cnt_reg == '0) begin
                state_reg <= DONE;
                miso_reg  <= 1'b0;
              end else begin
                miso_reg     <= rd_byte[DATA_W-1];
                tx_reg       <= {rd_byte[DATA_W-2:0], 1'b0};
                tx_bits_reg  <= 3'd7;
                rd_ptr_reg   <= rd_ptr_reg + 1'b1;
                byte_cnt_reg <= byte_cnt_reg - 1'b1;
              end
            end else begin
              miso_reg    <= tx_reg[DATA_W-1];
              tx_reg      <= {tx_reg[DATA_W-2:0], 1'b0};
              tx_bits_reg <= tx_bits_reg - 1'b1;
            end
          end
        end
        default: begin
          miso_reg <= 1'b0;
        end
      endcase

      if (timeout) begin
        state_reg       <= IDLE;
        bit_cnt_reg     <= '0;
        hdr_reg         <= '0;
        tx_reg          <= '0;
        tx_bits_reg     <= '0;
        miso_reg        <= 1'b0;
        frame_error_reg <= (state_reg == HDR) || (state_reg == RD_DATA);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
      assign regs_flat[gi*8 +: 8] = regs_mem[gi];
    end
  endgenerate

  assign spi.miso    = miso_reg;
  assign wr_strobe   = wr_strobe_reg;
  assign wr_addr     = wr_addr_reg;
  assign wr_data     = wr_data_reg;
  assign busy        = (state_reg != IDLE);
  assign frame_error = frame_error_reg;

endmodule
